// File: rtl/addr_demux_router.sv
// Single-master, two-slave request router with address decode, ack wait and bus-error timeout.
// Optional ADDR_ALIGN_CHECK_EN: odd addresses are rejected in IDLE with an immediate error completion.
module addr_demux_router #(
  parameter int                           ADDRESS_BUS_WIDTH = 16,
  parameter int                           DATA_BUS_WIDTH    = 16,
  parameter logic [ADDRESS_BUS_WIDTH-1:0] IO_BASE           = 16'hFF00,
  parameter int                           TIMEOUT           = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_req,
  input  logic                         m_we,
  input  logic [ADDRESS_BUS_WIDTH-1:0] m_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    m_wdata,
  output logic [DATA_BUS_WIDTH-1:0]    m_rdata,
  output logic                         m_ack,
  output logic                         m_err,
  output logic                         busy,
  output logic                         s0_req,
  output logic                         s0_we,
  output logic [ADDRESS_BUS_WIDTH-1:0] s0_addr,
  output logic [DATA_BUS_WIDTH-1:0]    s0_wdata,
  input  logic [DATA_BUS_WIDTH-1:0]    s0_rdata,
  input  logic                         s0_ack,
  output logic                         s1_req,
  output logic                         s1_we,
  output logic [ADDRESS_BUS_WIDTH-1:0] s1_addr,
  output logic [DATA_BUS_WIDTH-1:0]    s1_wdata,
  input  logic [DATA_BUS_WIDTH-1:0]    s1_rdata,
  input  logic                         s1_ack
);

  localparam int               CNT_W        = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic                         we_q, we_d;
  logic                         sel_q, sel_d;
  logic [ADDRESS_BUS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_BUS_WIDTH-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [DATA_BUS_WIDTH-1:0]    m_rdata_q, m_rdata_d;
  logic                         m_ack_q, m_ack_d;
  logic                         m_err_q, m_err_d;
  logic                         busy_q, busy_d;
  logic                         s0_req_q, s0_req_d, s1_req_q, s1_req_d;
  logic                         s0_we_q, s0_we_d, s1_we_q, s1_we_d;
  logic [ADDRESS_BUS_WIDTH-1:0] s0_addr_q, s0_addr_d, s1_addr_q, s1_addr_d;
  logic [DATA_BUS_WIDTH-1:0]    s0_wdata_q, s0_wdata_d, s1_wdata_q, s1_wdata_d;
  logic                         sel_ack_s;
  logic [DATA_BUS_WIDTH-1:0]    sel_rdata_s;

  // Next-state, transaction latch and completion logic
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    m_rdata_d = m_rdata_q;
    m_ack_d   = 1'b0;
    m_err_d   = 1'b0;
    if (sel_q) begin
      sel_ack_s   = s1_ack;
      sel_rdata_s = s1_rdata;
    end else begin
      sel_ack_s   = s0_ack;
      sel_rdata_s = s0_rdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          we_d    = m_we;
          addr_d  = m_addr;
          wdata_d = m_wdata;
          sel_d   = (m_addr >= IO_BASE);
          cnt_d   = '0;
`ifdef ADDR_ALIGN_CHECK_EN
          if (m_addr[0]) begin
            state_d = ST_DONE;
            m_ack_d = 1'b1;
            m_err_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
`else
          state_d = ST_WAIT;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A selected ack in the timeout cycle still counts as a normal completion.
        if (sel_ack_s) begin
          state_d = ST_DONE;
          m_ack_d = 1'b1;
          if (!we_q) begin
            m_rdata_d = sel_rdata_s;
          end else begin
            m_rdata_d = m_rdata_q;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_DONE;
          m_ack_d = 1'b1;
          m_err_d = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
          if (!we_q) begin
            m_rdata_d = '0;
          end else begin
            m_rdata_d = m_rdata_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Slave-side outputs follow the next state so they are registered yet aligned with WAIT
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    s0_req_d   = (state_d == ST_WAIT) && !sel_d;
    s1_req_d   = (state_d == ST_WAIT) && sel_d;
    s0_we_d    = s0_req_d && we_d;
    s1_we_d    = s1_req_d && we_d;
    if (s0_req_d) begin
      s0_addr_d  = addr_d;
      s0_wdata_d = wdata_d;
    end else begin
      s0_addr_d  = '0;
      s0_wdata_d = '0;
    end
    if (s1_req_d) begin
      s1_addr_d  = addr_d;
      s1_wdata_d = wdata_d;
    end else begin
      s1_addr_d  = '0;
      s1_wdata_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      sel_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      m_rdata_q  <= '0;
      m_ack_q    <= 1'b0;
      m_err_q    <= 1'b0;
      busy_q     <= 1'b0;
      s0_req_q   <= 1'b0;
      s1_req_q   <= 1'b0;
      s0_we_q    <= 1'b0;
      s1_we_q    <= 1'b0;
      s0_addr_q  <= '0;
      s1_addr_q  <= '0;
      s0_wdata_q <= '0;
      s1_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      m_rdata_q  <= m_rdata_d;
      m_ack_q    <= m_ack_d;
      m_err_q    <= m_err_d;
      busy_q     <= busy_d;
      s0_req_q   <= s0_req_d;
      s1_req_q   <= s1_req_d;
      s0_we_q    <= s0_we_d;
      s1_we_q    <= s1_we_d;
      s0_addr_q  <= s0_addr_d;
      s1_addr_q  <= s1_addr_d;
      s0_wdata_q <= s0_wdata_d;
      s1_wdata_q <= s1_wdata_d;
    end
  end

  assign m_rdata  = m_rdata_q;
  assign m_ack    = m_ack_q;
  assign m_err    = m_err_q;
  assign busy     = busy_q;
  assign s0_req   = s0_req_q;
  assign s1_req   = s1_req_q;
  assign s0_we    = s0_we_q;
  assign s1_we    = s1_we_q;
  assign s0_addr  = s0_addr_q;
  assign s1_addr  = s1_addr_q;
  assign s0_wdata = s0_wdata_q;
  assign s1_wdata = s1_wdata_q;

endmodule

// File: doc/addr_demux_router.md
Name: addr_demux_router

Overview:
- Single-master to two-slave bus router for the multicycle datapath; the distributing counterpart of the address/data selection muxes.
- Accepts one memory-style transaction, decodes the address, and steers it to main memory (slave 0) or memory-mapped I/O (slave 1).
- Holds the request until the slave acknowledges, returns read data, and flags timeouts as a bus error for exception-cause logic.

Parameters:
- ADDRESS_BUS_WIDTH, 16, address width.
- DATA_BUS_WIDTH, 16, data width.
- IO_BASE, 16'hFF00, lowest I/O address; addr >= IO_BASE selects slave 1, otherwise slave 0.
- TIMEOUT, 15, maximum WAIT cycles before a bus error; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- m_req  in  1  master request, sampled only in IDLE.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  ADDRESS_BUS_WIDTH  master address.
- m_wdata  in  DATA_BUS_WIDTH  master write data.
- m_rdata  out  DATA_BUS_WIDTH  registered read data.
- m_ack  out  1  one-cycle completion pulse.
- m_err  out  1  one-cycle error pulse, coincident with m_ack.
- busy  out  1  high whenever state is not IDLE.
- s0_req, s1_req  out  1  slave requests.
- s0_we, s1_we  out  1  slave write enables.
- s0_addr, s1_addr  out  ADDRESS_BUS_WIDTH  slave addresses.
- s0_wdata, s1_wdata  out  DATA_BUS_WIDTH  slave write data.
- s0_rdata, s1_rdata  in  DATA_BUS_WIDTH  slave read data.
- s0_ack, s1_ack  in  1  slave acknowledges.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs go to 0, including m_rdata, busy and the timeout counter.
  - Reset mid-transaction aborts it: no m_ack is produced and s*_req drops immediately.
- States:
  - IDLE: when m_req=1, latch we/addr/wdata, compute sel = (addr >= IO_BASE), clear the counter, go to WAIT.
  - WAIT: drive the selected slave's req/we/addr/wdata from the latched values. The unselected slave sees req=0 and we=0; its addr and wdata are 0.
  - DONE: one cycle; m_ack=1, then return to IDLE.
- Latency:
  - m_req sampled at edge 0; s_req is high from cycle 1.
  - A slave ack sampled at edge k moves the FSM to DONE, so m_ack is high during cycle k+1.
  - Minimum request-to-ack latency is 2 cycles.
- Read completion: m_rdata registers the selected slave's rdata on the ack edge.
- Write completion: m_rdata is left unchanged. m_rdata otherwise holds its value indefinitely.
- Ack handling: acks from the unselected slave are ignored. Any slave ack while in IDLE or DONE is ignored.
- Timeout:
  - The counter increments each WAIT cycle without an ack.
  - When the counter equals TIMEOUT, drop s_req, go to DONE with m_err=1, and set m_rdata=0 (reads only).
  - An ack arriving in the same cycle as the timeout wins: normal completion, no error.
- m_req while busy: ignored. The master must hold m_req until m_ack to be re-sampled; m_req high in DONE is not accepted until IDLE.
- Back-to-back transactions: with m_req held high, a new transaction is accepted in the IDLE cycle after DONE, giving 1 idle cycle between transactions.
- Decode boundaries:
  - addr = IO_BASE-1 goes to slave 0.
  - addr = IO_BASE goes to slave 1.
  - The all-ones address goes to slave 1.

Optional Feature:
- Macro: ADDR_ALIGN_CHECK_EN.
- Defined: in IDLE, an accepted request with m_addr[0]=1 raises no slave request. The FSM goes directly to DONE, so m_ack=1 and m_err=1 in cycle 1, and m_rdata is unchanged.
- Undefined: m_addr[0] is passed through unchecked and odd addresses are routed normally.

Test Plan:
- Read 0x0010, s0 acks 2 cycles after s0_req rises with s0_rdata=16'hBEEF -> s1_req stays 0; m_ack one cycle after the ack; m_rdata=16'hBEEF; m_err=0.
- Write 0xFF00 data 16'h1234 -> s1_req=1, s1_we=1, s1_wdata=16'h1234; s0_req=0; m_rdata unchanged after m_ack.
- Read 0xFEFF, no ack, TIMEOUT=15 -> s0_req drops after 15 WAIT cycles; next cycle m_ack=1, m_err=1, m_rdata=0.
- s1_ack pulsed during a slave-0 transaction -> ignored; completion only on s0_ack.
- rst asserted while in WAIT -> s0_req, busy and m_ack are 0 immediately; the FSM accepts a new m_req on the first edge after release.
- With ADDR_ALIGN_CHECK_EN, read 0x0011 -> no s*_req; m_ack=1 and m_err=1 one cycle after acceptance. Without the macro, s0_addr=0x0011.
